// File: rtl/alarm_ctrl.sv
// alarm_ctrl: serial-code alarm controller. Code bits arrive one per press of
// the enter button; a correct code arms or disarms, an armed system counts
// down an entry delay on intrusion before sounding the siren, and repeated
// wrong codes cause a lockout (disarmed) or an immediate alarm (armed).
module alarm_ctrl #(
    parameter int                  CODE_LEN     = 4,
    parameter logic [CODE_LEN-1:0] CODE         = 4'b0011,
    parameter int                  EXIT_CYCLES  = 20,
    parameter int                  ENTRY_CYCLES = 20,
    parameter int                  LOCK_CYCLES  = 40,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  IDLE_TO      = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in,
    input  logic                          s,
    input  logic                          sensor,
    output logic                          Y,
    output logic                          armed,
    output logic                          locked,
    output logic [2:0]                    state,
    output logic [$clog2(CODE_LEN+1)-1:0] bit_cnt
);
    localparam int BW    = $clog2(CODE_LEN + 1);
    localparam int TMAX1 = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int TMAX  = (TMAX1 > LOCK_CYCLES) ? TMAX1 : LOCK_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int IW    = $clog2(IDLE_TO + 1);
    localparam int FW    = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

    logic                r_sPrev;
    logic [CODE_LEN-2:0] r_code;
    logic [BW-1:0]       r_bitCnt;
    logic [IW-1:0]       r_idle;
    logic [FW-1:0]       r_fail;
    logic [TW-1:0]       r_timer;
    state_t              r_state;
    logic                r_y;
    logic                r_armed;
    logic                r_locked;

    logic                w_strobe;
    logic                w_accept;
    logic                w_last;
    logic [CODE_LEN-1:0] w_word;
    logic                w_codeOk;
    logic                w_codeBad;
    logic                w_timerZero;
    logic                w_failHit;
    state_t              w_nextState;
    logic [TW-1:0]       w_nextTimer;
    logic [FW-1:0]       w_nextFail;

    // Press detection and completed-word evaluation; the full word is the
    // stored bits plus the bit arriving with the final press.
    always_comb begin
        w_strobe    = s & ~r_sPrev;
        w_accept    = w_strobe && (r_state != ST_LOCKOUT);
        w_last      = w_accept && (r_bitCnt == BW'(CODE_LEN - 1));
        w_word      = {r_code, in};
        w_codeOk    = w_last && (w_word == CODE);
        w_codeBad   = w_last && (w_word != CODE);
        w_timerZero = (r_timer == '0);
        w_failHit   = ((int'(r_fail) + 1) >= MAX_FAIL);
    end

    // Next-state logic; code_ok beats code_bad beats timer expiry beats sensor.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        w_nextFail  = r_fail;
        case (r_state)
            ST_DISARMED: begin
                if (w_codeOk) begin
                    w_nextState = ST_EXIT;
                    w_nextTimer = TW'(EXIT_CYCLES - 1);
                    w_nextFail  = '0;
                end else if (w_codeBad) begin
                    if (w_failHit) begin
                        w_nextState = ST_LOCKOUT;
                        w_nextTimer = TW'(LOCK_CYCLES - 1);
                        w_nextFail  = '0;
                    end else begin
                        w_nextFail = r_fail + FW'(1);
                    end
                end
            end
            ST_EXIT: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextFail  = '0;
                end else if (w_timerZero) begin
                    w_nextState = ST_ARMED;
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            ST_ARMED: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextFail  = '0;
                end else if (w_codeBad) begin
                    if (w_failHit) begin
                        w_nextState = ST_ALARM;
                        w_nextFail  = '0;
                    end else begin
                        w_nextFail = r_fail + FW'(1);
                    end
                end else if (sensor) begin
                    w_nextState = ST_ENTRY;
                    w_nextTimer = TW'(ENTRY_CYCLES - 1);
                end
            end
            ST_ENTRY: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextFail  = '0;
                end else if (w_codeBad) begin
                    if (w_failHit) begin
                        w_nextState = ST_ALARM;
                        w_nextFail  = '0;
                    end else begin
                        w_nextFail = r_fail + FW'(1);
                        if (!w_timerZero) begin
                            w_nextTimer = r_timer - TW'(1);
                        end
                    end
                end else if (w_timerZero) begin
                    w_nextState = ST_ALARM;
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            ST_ALARM: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextFail  = '0;
                end
            end
            ST_LOCKOUT: begin
                if (w_timerZero) begin
                    w_nextState = ST_DISARMED;
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            default: begin
                w_nextState = ST_DISARMED;
            end
        endcase
    end

    // Code entry shift register, bit counter and partial-entry idle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sPrev  <= 1'b0;
            r_code   <= '0;
            r_bitCnt <= '0;
            r_idle   <= '0;
        end else begin
            r_sPrev <= s;
            if (r_state == ST_LOCKOUT) begin
                r_bitCnt <= '0;
                r_idle   <= '0;
            end else if (w_accept) begin
                r_code   <= w_word[CODE_LEN-2:0];
                r_bitCnt <= w_last ? '0 : r_bitCnt + BW'(1);
                r_idle   <= '0;
            end else if (r_bitCnt != '0) begin
                if (r_idle == IW'(IDLE_TO - 1)) begin
                    r_bitCnt <= '0;
                    r_idle   <= '0;
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end else begin
                r_idle <= '0;
            end
        end
    end

    // Main FSM registers with outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_DISARMED;
            r_timer  <= '0;
            r_fail   <= '0;
            r_y      <= 1'b0;
            r_armed  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_timer  <= w_nextTimer;
            r_fail   <= w_nextFail;
            r_y      <= (w_nextState == ST_ALARM);
            r_armed  <= (w_nextState == ST_ARMED) || (w_nextState == ST_ENTRY);
            r_locked <= (w_nextState == ST_LOCKOUT);
        end
    end

    assign Y       = r_y;
    assign armed   = r_armed;
    assign locked  = r_locked;
    assign state   = r_state;
    assign bit_cnt = r_bitCnt;

endmodule
